// File: rtl/tile_command_encoder.sv
// tile_command_encoder
//   Producer side of the 32-bit tile control-word link into the VGA tile
//   mapper. Tile-write requests are queued in a small FIFO. Each request is
//   driven as an opcode-2 word for HOLD cycles, followed by GAP idle cycles,
//   so the mapper latches every write exactly once. A bulk fill command
//   rewrites every tile of the COLS x ROWS map with a single index.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     tile-write handshake (ready = FIFO not full)
//   req_col/req_row/        tile coordinates and sprite index of a request
//   req_index
//   fill_valid/fill_ready   bulk-fill handshake (only when idle and drained)
//   fill_index              index written to every tile by a fill
//   control                 registered control word to the mapper
//   busy                    registered: FSM active or FIFO holds requests
//   err                     registered one-cycle pulse: out-of-range request dropped
module tile_command_encoder #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1,
    parameter int COLS  = 40,
    parameter int ROWS  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_col,
    input  logic [5:0]  req_row,
    input  logic [7:0]  req_index,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [7:0]  fill_index,
    output logic [31:0] control,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(((HOLD > GAP) ? HOLD : GAP) + 1);
    localparam logic [3:0] OP_WRITE = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_FILL_WRITE,
        S_FILL_GAP
    } state_t;

    // Request FIFO: entries are {col, row, index}.
    logic [19:0]   mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_empty;
    logic          fifo_full;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [19:0]   word_reg;
    logic [5:0]    fill_col_reg;
    logic [5:0]    fill_row_reg;
    logic [7:0]    fill_idx_reg;

    logic          req_fire;
    logic          req_oor;
    logic          push;
    logic          pop;
    logic          fill_start;
    logic          fill_adv;

    logic [31:0]   control_next;
    logic          busy_next;
    logic          err_next;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign req_ready  = !fifo_full;
    assign fill_ready = (state_reg == S_IDLE) && fifo_empty && !req_valid;

    assign req_fire = req_valid && req_ready;
    assign req_oor  = (32'(req_col) >= COLS) || (32'(req_row) >= ROWS);
    // Out-of-range requests complete the handshake but never reach the FIFO.
    assign push     = req_fire && !req_oor;

    // FIFO payload storage carries no reset; validity lives in count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {req_col, req_row, req_index};
        end
    end

    // Next-state logic. A drained GAP pops the next request straight into
    // WRITE so back-to-back requests see no idle bubble.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        fill_start = 1'b0;
        fill_adv   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cnt_next   = '0;
                    state_next = S_WRITE;
                end else if (fill_valid && fill_ready) begin
                    fill_start = 1'b1;
                    cnt_next   = '0;
                    state_next = S_FILL_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_reg == CW'(HOLD - 1)) begin
                    cnt_next   = '0;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_reg == CW'(GAP - 1)) begin
                    cnt_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_FILL_WRITE: begin
                if (cnt_reg == CW'(HOLD - 1)) begin
                    cnt_next   = '0;
                    state_next = S_FILL_GAP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_FILL_GAP: begin
                if (cnt_reg == CW'(GAP - 1)) begin
                    cnt_next = '0;
                    if ((fill_col_reg == 6'(COLS - 1)) && (fill_row_reg == 6'(ROWS - 1))) begin
                        state_next = S_IDLE;
                    end else begin
                        fill_adv   = 1'b1;
                        state_next = S_FILL_WRITE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // State register plus FIFO pointers and the fill cursor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            word_reg     <= '0;
            fill_col_reg <= '0;
            fill_row_reg <= '0;
            fill_idx_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                word_reg   <= mem_reg[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (fill_start) begin
                fill_idx_reg <= fill_index;
                fill_col_reg <= '0;
                fill_row_reg <= '0;
            end else if (fill_adv) begin
                if (fill_col_reg == 6'(COLS - 1)) begin
                    fill_col_reg <= '0;
                    fill_row_reg <= fill_row_reg + 6'd1;
                end else begin
                    fill_col_reg <= fill_col_reg + 6'd1;
                end
            end
        end
    end

    // Output logic, decoded from the current state; registered below, so the
    // control word trails the state by one cycle.
    always_comb begin
        control_next = '0;
        case (state_reg)
            S_WRITE:      control_next = {OP_WRITE, word_reg[19:14], word_reg[13:8], 8'h00, word_reg[7:0]};
            S_FILL_WRITE: control_next = {OP_WRITE, fill_col_reg, fill_row_reg, 8'h00, fill_idx_reg};
            default:      control_next = '0;
        endcase
        busy_next = (state_reg != S_IDLE) || !fifo_empty;
        err_next  = req_fire && req_oor;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            control <= control_next;
            busy    <= busy_next;
            err     <= err_next;
        end
    end

endmodule

// File: tb/tb_tile_command_encoder.sv
// tb_tile_command_encoder
//   Directed bench for tile_command_encoder: single write timing, back-to-back
//   queueing, out-of-range drops, full-screen fill, request during fill and
//   reset during a write. Inputs change 1 ns after the rising edge and outputs
//   are read at that same point.
module tb_tile_command_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_col = '0;
    logic [5:0]  req_row = '0;
    logic [7:0]  req_index = '0;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [7:0]  fill_index = '0;
    logic [31:0] control;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic        cap = 1'b0;
    logic [31:0] trace [$];

    always #5 clk = ~clk;

    tile_command_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_col    (req_col),
        .req_row    (req_row),
        .req_index  (req_index),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_index (fill_index),
        .control    (control),
        .busy       (busy),
        .err        (err)
    );

    always @(negedge clk) begin
        if (cap) trace.push_back(control);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] wword(input logic [5:0] c, input logic [5:0] r, input logic [7:0] i);
        return {4'h2, c, r, 8'h00, i};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns 1 ns after the accepting edge.
    task automatic send_req(input logic [5:0] c, input logic [5:0] r, input logic [7:0] i);
        for (int n = 0; n < 100 && !req_ready; n++) tick();
        if (!req_ready) begin
            check("req_ready_wait", 32'(req_ready), 32'd1);
        end else begin
            req_col   = c;
            req_row   = r;
            req_index = i;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic send_fill(input logic [7:0] i);
        for (int n = 0; n < 100 && !fill_ready; n++) tick();
        if (!fill_ready) begin
            check("fill_ready_wait", 32'(fill_ready), 32'd1);
        end else begin
            fill_index = i;
            fill_valid = 1'b1;
            tick();
            fill_valid = 1'b0;
        end
    endtask

    initial begin
        logic [5:0] t2_col [7] = '{6'd0, 6'd39, 6'd0,  6'd20, 6'd1, 6'd3, 6'd7};
        logic [5:0] t2_row [7] = '{6'd0, 6'd0,  6'd29, 6'd15, 6'd2, 6'd4, 6'd9};
        logic [7:0] t2_idx [7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        logic [31:0] run_val [$];
        int          run_len [$];
        int          run_gap [$];
        int          zero_run;
        int          k;
        bit          saw_low;
        bit          seen_word;
        int          nz, words, cyc, started;
        logic [31:0] first_w, last_w, w41, prev;
        int          last_fill, first_req, req_hits;

        // ---------------- reset state ----------------
        #23;
        check("rst_control", control, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        tick();
        tick();

        // ---------------- test 1: single write ----------------
        send_req(6'd5, 6'd3, 8'h01);       // accepted at edge t
        check("t1_ctrl_t1", control, 32'h0);
        check("t1_err", 32'(err), 32'd0);
        tick();                            // after t+1: pop
        check("t1_ctrl_t2", control, 32'h0);
        tick();                            // after t+2: word visible
        check("t1_word_a", control, 32'h21430001);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        check("t1_word_b", control, 32'h21430001);
        tick();
        check("t1_gap", control, 32'h0);
        tick();
        check("t1_after", control, 32'h0);
        tick();
        tick();
        check("t1_busy_low", 32'(busy), 32'd0);

        // ---------------- test 2: back-to-back queue ----------------
        trace.delete();
        cap = 1'b1;
        k = 0;
        saw_low = 1'b0;
        req_col = t2_col[0]; req_row = t2_row[0]; req_index = t2_idx[0];
        req_valid = 1'b1;
        for (int c = 0; c < 200 && k < 7; c++) begin
            automatic logic rdy = req_ready;
            if (!rdy) saw_low = 1'b1;
            tick();
            if (rdy) begin
                k++;
                if (k < 7) begin
                    req_col = t2_col[k]; req_row = t2_row[k]; req_index = t2_idx[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check("t2_all_accepted", 32'(k), 32'd7);
        check("t2_ready_went_low", 32'(saw_low), 32'd1);
        for (int c = 0; c < 40; c++) tick();
        cap = 1'b0;
        zero_run = 0;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i] == 32'h0) begin
                zero_run++;
            end else if (i > 0 && trace[i] == trace[i-1]) begin
                run_len[run_len.size()-1]++;
            end else begin
                run_val.push_back(trace[i]);
                run_len.push_back(1);
                run_gap.push_back(zero_run);
                zero_run = 0;
            end
        end
        check("t2_word_count", 32'(run_val.size()), 32'd7);
        for (int i = 0; i < 7 && i < run_val.size(); i++) begin
            check($sformatf("t2_word%0d", i), run_val[i], wword(t2_col[i], t2_row[i], t2_idx[i]));
            check($sformatf("t2_hold%0d", i), 32'(run_len[i]), 32'd2);
            if (i > 0) check($sformatf("t2_gap%0d", i), 32'(run_gap[i]), 32'd1);
        end
        check("t2_busy_low", 32'(busy), 32'd0);

        // ---------------- test 3: out-of-range drops ----------------
        send_req(6'd40, 6'd0, 8'h55);
        check("t3_err_col40", 32'(err), 32'd1);
        tick();
        check("t3_err_pulse_end", 32'(err), 32'd0);
        seen_word = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (control != 32'h0 || busy) seen_word = 1'b1;
            tick();
        end
        check("t3_no_word_col40", 32'(seen_word), 32'd0);
        send_req(6'd0, 6'd30, 8'h56);
        check("t3_err_row30", 32'(err), 32'd1);
        tick();
        check("t3_busy_row30", 32'(busy), 32'd0);
        send_req(6'd39, 6'd29, 8'hA5);     // corner tile is legal
        check("t3_err_corner", 32'(err), 32'd0);
        tick();
        tick();
        check("t3_corner_word", control, 32'h29DD00A5);
        for (int c = 0; c < 6; c++) tick();

        // ---------------- test 4: full-screen fill ----------------
        send_fill(8'h01);
        nz = 0; words = 0; cyc = 0; started = 0;
        first_w = '0; last_w = '0; w41 = '0; prev = '0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (c == 10) check("t4_fill_ready_low", 32'(fill_ready), 32'd0);
            if (control != 32'h0) begin
                if (!started) first_w = control;
                started = 1;
                nz++;
                if (prev == 32'h0) begin
                    words++;
                    if (words == 41) w41 = control;
                end
                last_w = control;
            end
            if (started && !busy) break;
            if (started) cyc++;
            prev = control;
        end
        check("t4_first_word", first_w, 32'h20000001);
        check("t4_wrap_word", w41, 32'h20010001);
        check("t4_last_word", last_w, 32'h29DD0001);
        check("t4_word_count", 32'(words), 32'd1200);
        check("t4_hold_cycles", 32'(nz), 32'd2400);
        check("t4_duration", 32'(cyc), 32'd3600);
        check("t4_idle_ctrl", control, 32'h0);
        tick();
        check("t4_fill_ready_idle", 32'(fill_ready), 32'd1);

        // ---------------- test 5: request during fill ----------------
        send_fill(8'h01);
        for (int c = 0; c < 50; c++) tick();
        send_req(6'd1, 6'd1, 8'h07);
        check("t5_err", 32'(err), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        last_fill = -1; first_req = -1; req_hits = 0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (control == 32'h29DD0001) last_fill = c;
            if (control == 32'h20410007) begin
                req_hits++;
                if (first_req < 0) first_req = c;
            end
            if (first_req >= 0 && !busy) break;
        end
        check("t5_last_fill_seen", 32'(last_fill >= 0), 32'd1);
        check("t5_req_seen", 32'(first_req >= 0), 32'd1);
        check("t5_req_after_gap", 32'(first_req >= last_fill + 2), 32'd1);
        check("t5_req_hold", 32'(req_hits), 32'd2);
        for (int c = 0; c < 4; c++) tick();

        // ---------------- test 6: reset during hold ----------------
        send_req(6'd10, 6'd2, 8'h33);
        send_req(6'd11, 6'd2, 8'h34);
        for (int c = 0; c < 20 && control != wword(6'd10, 6'd2, 8'h33); c++) tick();
        check("t6_word_seen", control, wword(6'd10, 6'd2, 8'h33));
        #2 reset = 1'b1;
        #1;
        check("t6_async_ctrl", control, 32'h0);
        check("t6_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_word = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (control != 32'h0) seen_word = 1'b1;
        end
        check("t6_no_reemit", 32'(seen_word), 32'd0);
        check("t6_fifo_empty", 32'(busy), 32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_command_encoder.md
Name: tile_command_encoder

Overview:
- Producer side of the 32-bit tile control-word interface consumed by the VGA tile mapper.
- Game logic issues tile-write requests over a valid/ready handshake. The block buffers them and serialises each into a control word.
- Each word is held for a fixed number of cycles, followed by an idle gap, so the mapper latches every write exactly as encoded.
- Also provides a bulk "fill" command that rewrites all 40x30 tiles with one index (screen clear / level init).

Parameters:
- DEPTH, 4, request FIFO entries (power of two, >=2).
- HOLD, 2, cycles each write word is driven with opcode 2 (>=1).
- GAP, 1, cycles of opcode 0 driven after each write word (>=1).
- COLS, 40, tile columns; valid column range 0..COLS-1.
- ROWS, 30, tile rows; valid row range 0..ROWS-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  tile-write request present.
- req_ready  output  1  FIFO can accept a request (not full).
- req_col  input  6  tile column.
- req_row  input  6  tile row.
- req_index  input  8  sprite index to write.
- fill_valid  input  1  bulk-fill request.
- fill_ready  output  1  fill accepted this cycle.
- fill_index  input  8  index written to every tile.
- control  output  32  control word to mapper, registered.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- err  output  1  one-cycle pulse: out-of-range request dropped.

Behaviour:
- Control word: [31:28] opcode, [27:22] column, [21:16] row, [15:8] zero, [7:0] index.
  - Opcode 2 = tile write; opcode 0 = idle.
  - Word with opcode 0 is all zeros.
- Reset (asynchronous): FIFO emptied; FSM IDLE; all counters 0; control=0; err=0; busy=0.
- Reset asserted mid-write or mid-fill aborts the operation; control returns to 0 immediately.
- Request handshake: transfer when req_valid && req_ready; req_ready = !fifo_full.
  - Out-of-range transfer (col>=COLS or row>=ROWS) is consumed but not enqueued; err pulses high the following cycle.
  - Enqueue and dequeue in the same cycle while full: not allowed (req_ready low when full). While non-empty: count unchanged.
- Fill handshake: fill_ready = (state==IDLE) && fifo_empty && !req_valid.
  - A pending request takes precedence over a fill.
- FSM states:
  - IDLE: control=0.
    - If FIFO non-empty: pop head, load word, go to WRITE.
    - Else if fill accepted: latch fill_index, col=row=0, go to FILL_WRITE.
  - WRITE: control = write word for HOLD cycles (hold counter), then go to GAP.
  - GAP: control=0 for GAP cycles.
    - Then pop the next FIFO entry directly into WRITE if non-empty (no IDLE bubble), else go to IDLE.
  - FILL_WRITE: control = opcode 2 for current col/row with the latched index, for HOLD cycles, then go to FILL_GAP.
  - FILL_GAP: control=0 for GAP cycles, then advance row-major: col+1; wrap col COLS-1 -> 0 with row+1.
    - After tile (COLS-1, ROWS-1): go to IDLE.
    - Otherwise go to FILL_WRITE.
- Requests arriving during a fill are enqueued normally (up to DEPTH) and served after the fill completes.
- Latency: request accepted at edge t with FSM IDLE and FIFO empty -> FIFO write at t, pop at t+1, write word visible on control after edge t+2.
- Fill duration: COLS*ROWS*(HOLD+GAP) cycles from first FILL_WRITE cycle; 3600 with defaults.
- control, busy, err are registered outputs.

Test Plan:
1. Reset, then single request col=5,row=3,idx=0x01 -> control=0x21430001 for exactly 2 cycles, then 0x00000000 for 1 cycle, then 0; busy falls after the gap.
2. Back-to-back: 5 requests with req_valid held -> req_ready low once 4 queued; all 5 words emitted in order; pattern 2 cycles word / 1 cycle zero; no extra idle cycle between words.
3. Out-of-range col=40,row=0 -> err high one cycle; no opcode-2 word emitted; FIFO count unchanged.
4. Fill with fill_index=0x01 -> first word 0x20000001; last word 0x29DD0001 (col 39,row 29); 1200 distinct words; total 3600 cycles; then IDLE.
5. Request col=1,row=1,idx=0x07 issued mid-fill -> accepted; emitted as 0x20410007 only after the final fill gap.
6. Assert reset during the HOLD phase of a write -> control=0 asynchronously; FIFO empty; the interrupted word is not re-emitted after reset release.
